rand_matrix_fill_ctrl: RTL and testbench
========================================

Name: rand_matrix_fill_ctrl

Overview:
Sequences the shared xorshift32 generator to fill one matrix in matrix BRAM with random elements. On start it steps the RNG one batch (NUM_OUTPUTS words) at a time and buffers the batch. It then writes one element per accepted cycle, in row-major order, from base_addr. It sits between the matrix-op dispatcher (command side) and the matrix storage write port.

Parameters:
NUM_OUTPUTS, 4, words produced per RNG step; must match the xorshift32 instance
ELEM_WIDTH, 16, stored element width (≤32)
DIM_WIDTH, 8, width of rows/cols
ADDR_WIDTH, 16, matrix storage address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle command pulse; sampled only in IDLE
abort  in  1  cancel current fill
rows  in  DIM_WIDTH  row count, latched on start
cols  in  DIM_WIDTH  column count, latched on start
seed  in  32  RNG seed, latched on start
base_addr  in  ADDR_WIDTH  first element address, latched on start
max_val  in  ELEM_WIDTH  clamp limit, latched on start (used only with the optional feature)
rng_seed  out  32  latched seed, held to the RNG
rng_start  out  1  one-cycle pulse; RNG advances one step per high cycle
rng_data  in  NUM_OUTPUTS*32  RNG outputs, word i at bits [32i+31:32i]; valid the cycle after a rng_start pulse
wr_en  out  1  element write valid
wr_addr  out  ADDR_WIDTH  element address
wr_data  out  ELEM_WIDTH  element value
wr_ready  in  1  storage accepts; a write transfers when wr_en && wr_ready
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse after the last element transfers
aborted  out  1  1-cycle pulse when abort takes effect

Behaviour:
- Reset values: every output is 0, state is IDLE, all counters and the buffer are cleared.
- States: IDLE, REQ, WAIT, LATCH, WRITE, FIN.
- IDLE: on start, latch the inputs and compute total = rows*cols (2*DIM_WIDTH bits). Clear the element index idx and the batch slot k.
  - total==0: go to FIN.
  - Otherwise go to REQ.
- REQ: rng_start=1 for exactly this cycle, then go to WAIT.
- WAIT: one cycle, then go to LATCH.
- LATCH: capture all NUM_OUTPUTS words of rng_data into the buffer, set k=0, go to WRITE.
- WRITE:
  - wr_en=1, wr_addr=base_addr+idx (truncated mod 2^ADDR_WIDTH, wrap allowed), wr_data=elem(buffer[k]).
  - On a transfer: idx++, k++.
  - If idx+1==total: go to FIN.
  - Else if k==NUM_OUTPUTS-1: go to REQ.
  - Without wr_ready: hold wr_en, wr_addr and wr_data stable.
- Unused words of the final partial batch are discarded.
- FIN: done=1 for one cycle, then go to IDLE.
- elem(w) = w[ELEM_WIDTH-1:0] (see Optional Feature).
- Throughput with wr_ready held high: NUM_OUTPUTS writes per NUM_OUTPUTS+3 cycles.
- Latency: first wr_en is asserted 4 cycles after the start cycle (start→REQ→WAIT→LATCH→WRITE).
- start while busy: ignored; latched values are unchanged.
- abort is honoured in any non-IDLE state:
  - Next state is IDLE and aborted=1 for one cycle.
  - No done pulse; wr_en drops the next cycle.
  - A write transferring in the same cycle still counts as transferred.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- rng_seed tracks the latched seed continuously. The RNG loads it on its own start edge (the RNG's contract). The controller never re-seeds mid-fill.
- Asynchronous reset mid-fill: immediate return to the reset values. The storage contents written so far are unspecified.

Optional Feature:
RAND_FILL_CLAMP_EN
- Defined: elem(w) = min(w[ELEM_WIDTH-1:0], max_val), unsigned compare, registered in LATCH. Latency is unchanged.
- Undefined: elem(w) = w[ELEM_WIDTH-1:0]; the max_val input is ignored.

Test Plan:
- Reset: rst_n low mid-WRITE → all outputs 0 immediately; busy=0; no done.
- rows=2, cols=3, seed=123456789, base_addr=0x0100, wr_ready=1 → writes to 0x0100..0x0105 equal low 16 bits of RNG words 0..5. rng_start pulses 2 times. Words 6–7 discarded. done 1 cycle after the 6th transfer.
- Same fill with wr_ready toggling 1,0,0,1,… → wr_addr and wr_data stable while stalled. Exactly 6 transfers, identical data to the previous case.
- rows=0, cols=5 → no wr_en, no rng_start; done pulse 1 cycle after the start cycle.
- abort asserted on the 3rd transfer cycle of a 4×4 fill → 3 writes counted; aborted pulse; no done. A following start with rows=1, cols=1 completes normally.
- base_addr=0xFFFE, rows=1, cols=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- With RAND_FILL_CLAMP_EN, max_val=0x00FF → every wr_data ≤ 0x00FF. Values below the limit equal the raw low 16 bits.

Source files
------------

// File: rtl/rand_matrix_fill_ctrl.sv
// rand_matrix_fill_ctrl
//   Drives a shared xorshift32 generator to fill one matrix in matrix storage
//   with random elements. Each step of the RNG produces NUM_OUTPUTS words. The
//   controller buffers one batch and then writes one element per accepted
//   cycle, in row-major order, starting at base_addr.
//
//   Optional build macro: RAND_FILL_CLAMP_EN
//     defined   : element = min(word[ELEM_WIDTH-1:0], max_val), applied when
//                 the batch is captured
//     undefined : element = word[ELEM_WIDTH-1:0]; i_max_val is ignored
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start, i_abort   command pulse (sampled in IDLE) / cancel the current fill
//   i_rows, i_cols     matrix dimensions, latched on start
//   i_seed             RNG seed, latched on start and held on o_rng_seed
//   i_base_addr        address of element 0, latched on start
//   i_max_val          clamp limit, latched on start (clamp build only)
//   o_rng_start        one-cycle step request to the RNG
//   i_rng_data         RNG batch, word i at [32i+31:32i], valid the cycle after a step
//   o_wr_en/addr/data  element write port, transfer on o_wr_en && i_wr_ready
//   o_busy             high in any state other than IDLE
//   o_done             one-cycle pulse after the last element transfers
//   o_aborted          one-cycle pulse in the cycle after an abort is honoured
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_REQ   | pulse o_rng_start to advance the RNG one batch
// S_WAIT  | RNG output settling
// S_LATCH | capture the batch into the element buffer
// S_WRITE | present buffer[k] at base_addr+idx until accepted
// S_FIN   | pulse o_done
module rand_matrix_fill_ctrl #(
  parameter int NUM_OUTPUTS = 4,
  parameter int ELEM_WIDTH  = 16,
  parameter int DIM_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [DIM_WIDTH-1:0]      i_rows,
  input  logic [DIM_WIDTH-1:0]      i_cols,
  input  logic [31:0]               i_seed,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [ELEM_WIDTH-1:0]     i_max_val,
  output logic [31:0]               o_rng_seed,
  output logic                      o_rng_start,
  input  logic [NUM_OUTPUTS*32-1:0] i_rng_data,
  output logic                      o_wr_en,
  output logic [ADDR_WIDTH-1:0]     o_wr_addr,
  output logic [ELEM_WIDTH-1:0]     o_wr_data,
  input  logic                      i_wr_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_aborted
);

  localparam int KW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int TW = 2 * DIM_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [31:0]             r_seed;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [TW-1:0]           r_total;
  logic [TW-1:0]           r_idx;
  logic [KW-1:0]           r_k;
  logic [ELEM_WIDTH-1:0]   r_buf [NUM_OUTPUTS];
  logic                    r_aborted;

  logic [TW-1:0]           w_total;
  logic [ELEM_WIDTH-1:0]   w_elem [NUM_OUTPUTS];
  logic                    w_xfer;
  logic                    w_last;
  logic                    w_k_last;
  logic                    w_unused;

`ifdef RAND_FILL_CLAMP_EN
  logic [ELEM_WIDTH-1:0]   r_max_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_max_val <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_max_val <= i_max_val;
    end
  end

  // Only the low ELEM_WIDTH bits of each RNG word are stored.
  assign w_unused = ^i_rng_data;
`else
  assign w_unused = ^{i_max_val, i_rng_data};
`endif

  assign w_total = {{DIM_WIDTH{1'b0}}, i_rows} * {{DIM_WIDTH{1'b0}}, i_cols};

  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      w_elem[i] = i_rng_data[32*i +: ELEM_WIDTH];
`ifdef RAND_FILL_CLAMP_EN
      if (w_elem[i] > r_max_val) begin
        w_elem[i] = r_max_val;
      end
`endif
    end
  end

  assign w_xfer   = (r_state == S_WRITE) && i_wr_ready;
  assign w_last   = ((r_idx + TW'(1)) == r_total);
  assign w_k_last = (r_k == KW'(NUM_OUTPUTS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_rng_start = 1'b0;
    o_wr_en     = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = (w_total == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        o_rng_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_wr_en = 1'b1;
        if (w_xfer) begin
          if (w_last) begin
            w_state_nxt = S_FIN;
          end else if (w_k_last) begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_FIN: begin
        o_done      = !i_abort;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides every non-IDLE transition; a write accepted in the
    // same cycle still advances idx below.
    if (r_state != S_IDLE && i_abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seed    <= '0;
      r_base    <= '0;
      r_total   <= '0;
      r_idx     <= '0;
      r_k       <= '0;
      r_aborted <= 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_aborted <= i_abort && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_seed  <= i_seed;
            r_base  <= i_base_addr;
            r_total <= w_total;
            r_idx   <= '0;
            r_k     <= '0;
          end
        end
        S_LATCH: begin
          for (int i = 0; i < NUM_OUTPUTS; i++) begin
            r_buf[i] <= w_elem[i];
          end
          r_k <= '0;
        end
        S_WRITE: begin
          if (w_xfer) begin
            r_idx <= r_idx + TW'(1);
            r_k   <= r_k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rng_seed = r_seed;
  assign o_aborted  = r_aborted;
  // Address wraps modulo 2^ADDR_WIDTH.
  assign o_wr_addr  = o_wr_en ? (r_base + ADDR_WIDTH'(r_idx)) : '0;
  assign o_wr_data  = o_wr_en ? r_buf[r_k] : '0;

endmodule

// File: tb/tb_rand_matrix_fill_ctrl.sv
module tb_rand_matrix_fill_ctrl;

  localparam int N  = 4;
  localparam int EW = 16;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] rows = '0;
  logic [DW-1:0] cols = '0;
  logic [31:0]   seed = '0;
  logic [AW-1:0] base = '0;
  logic [EW-1:0] maxv = 16'h00FF;
  logic [31:0]   o_rng_seed;
  logic          o_rng_start;
  logic [N*32-1:0] rng_data;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [EW-1:0] o_wr_data;
  logic          wr_ready = 1'b1;
  logic          o_busy, o_done, o_aborted;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  rand_matrix_fill_ctrl #(.NUM_OUTPUTS(N), .ELEM_WIDTH(EW), .DIM_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_rows(rows), .i_cols(cols), .i_seed(seed), .i_base_addr(base), .i_max_val(maxv),
    .o_rng_seed(o_rng_seed), .o_rng_start(o_rng_start), .i_rng_data(rng_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .i_wr_ready(wr_ready),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Reference: element j of a fill is the (j+1)-th xorshift successor of the seed.
  function automatic logic [EW-1:0] ref_elem(input logic [31:0] s, input int j, input logic [EW-1:0] mv);
    logic [31:0] x;
    logic [EW-1:0] e;
    x = s;
    for (int t = 0; t <= j; t++) x = xs(x);
    e = x[EW-1:0];
`ifdef RAND_FILL_CLAMP_EN
    if (e > mv) e = mv;
`else
    if (mv == mv) e = e;
`endif
    return e;
  endfunction

  // RNG stand-in: loads the held seed on its first step after IDLE, then
  // continues its sequence; each step yields N successive words.
  logic [31:0] rng_st;
  bit          rng_fresh;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_data  <= '0;
      rng_st    <= '0;
      rng_fresh <= 1'b1;
    end else begin
      if (!o_busy) rng_fresh <= 1'b1;
      if (o_rng_start) begin
        logic [31:0] x;
        logic [N*32-1:0] nd;
        x = rng_fresh ? o_rng_seed : rng_st;
        for (int i = 0; i < N; i++) begin
          x = xs(x);
          nd[32*i +: 32] = x;
        end
        rng_data  <= nd;
        rng_st    <= x;
        rng_fresh <= 1'b0;
      end
    end
  end

  // wr_ready patterns: 0 always high, 1 = 1,0,0 repeating, 2 random
  int rmode = 0;
  int rphase = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: begin wr_ready = (rphase == 0); rphase = (rphase + 1) % 3; end
      2: wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = 1'b1;
    endcase
  end

  // Monitor, sampled mid-cycle.
  logic [AW-1:0] qa[$];
  logic [EW-1:0] qd[$];
  int rng_cnt, done_cnt, done_cyc, ab_cnt, first_wr, last_x, stall_viol;
  bit prev_stall;
  logic [AW-1:0] p_addr;
  logic [EW-1:0] p_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (prev_stall && (o_wr_addr !== p_addr || o_wr_data !== p_data)) stall_viol++;
        if (wr_ready) begin
          qa.push_back(o_wr_addr);
          qd.push_back(o_wr_data);
          last_x = cyc;
        end
        prev_stall = !wr_ready;
        p_addr = o_wr_addr;
        p_data = o_wr_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (o_rng_start) rng_cnt++;
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_aborted) ab_cnt++;
    end
  end

  int st_cyc;

  task automatic clear_mon();
    qa.delete(); qd.delete();
    rng_cnt = 0; done_cnt = 0; done_cyc = -1; ab_cnt = 0;
    first_wr = -1; last_x = -1; stall_viol = 0; prev_stall = 1'b0;
  endtask

  task automatic do_start(input int r, input int c, input logic [31:0] s, input logic [AW-1:0] b);
    @(posedge clk); #1;
    rows = DW'(r); cols = DW'(c); seed = s; base = b; start = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int k;
    k = 0;
    while (done_cnt == 0 && ab_cnt == 0 && k < 3000) begin
      @(posedge clk); k++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (k >= 3000) $display("FAIL %s timeout: no done/aborted within %0d cycles", nm, k);
    else n_pass++;
  endtask

  task automatic check_fill(input string nm, input int r, input int c, input logic [31:0] s,
                            input logic [AW-1:0] b);
    int total, nb;
    logic [AW-1:0] ea;
    logic [EW-1:0] ed;
    total = r * c;
    nb = (total + N - 1) / N;
    n_chk++;
    if (qa.size() != total) $display("FAIL %s xfer_count got %0d want %0d", nm, qa.size(), total);
    else n_pass++;
    for (int j = 0; j < total && j < qa.size(); j++) begin
      ea = AW'(int'(b) + j);
      ed = ref_elem(s, j, maxv);
      n_chk++;
      if (qa[j] !== ea || qd[j] !== ed)
        $display("FAIL %s elem%0d got addr=%h data=%h want addr=%h data=%h", nm, j, qa[j], qd[j], ea, ed);
      else n_pass++;
`ifdef RAND_FILL_CLAMP_EN
      n_chk++;
      if (qd[j] > maxv) $display("FAIL %s clamp%0d got %h limit %h", nm, j, qd[j], maxv);
      else n_pass++;
`endif
    end
    n_chk++;
    if (rng_cnt != nb) $display("FAIL %s rng_start_count got %0d want %0d", nm, rng_cnt, nb);
    else n_pass++;
    n_chk++;
    if (done_cnt != 1) $display("FAIL %s done_count got %0d want 1", nm, done_cnt);
    else n_pass++;
    n_chk++;
    if (total > 0) begin
      if (done_cyc != last_x + 1 || first_wr != st_cyc + 4)
        $display("FAIL %s timing got first_wr=%0d done=%0d want first_wr=%0d done=%0d",
                 nm, first_wr - st_cyc, done_cyc - st_cyc, 4, last_x + 1 - st_cyc);
      else n_pass++;
    end else begin
      if (done_cyc != st_cyc + 1 || first_wr != -1)
        $display("FAIL %s empty_timing got done=%0d wr_seen=%0d want done=1 wr_seen=-1",
                 nm, done_cyc - st_cyc, first_wr);
      else n_pass++;
    end
    n_chk++;
    if (stall_viol != 0 || o_busy !== 1'b0 || ab_cnt != 0)
      $display("FAIL %s stall/idle got viol=%0d busy=%b aborted=%0d want 0 0 0", nm, stall_viol, o_busy, ab_cnt);
    else n_pass++;
  endtask

  task automatic run_fill(input string nm, input int r, input int c, input logic [31:0] s,
                          input logic [AW-1:0] b, input int mode);
    rmode = mode; rphase = 0;
    clear_mon();
    do_start(r, c, s, b);
    wait_end(nm);
    check_fill(nm, r, c, s, b);
    rmode = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({o_wr_en, o_busy, o_done, o_aborted, o_rng_start} !== 5'b0 || o_wr_addr !== '0 ||
        o_wr_data !== '0 || o_rng_seed !== '0)
      $display("FAIL reset_hold got en=%b busy=%b done=%b ab=%b rs=%b want all 0",
               o_wr_en, o_busy, o_done, o_aborted, o_rng_start);
    else n_pass++;
    rst_n = 1'b1;
    clear_mon();
    do_start(3, 3, 32'hCAFE_F00D, 16'h0040);
    n_chk++;
    if (o_busy !== 1'b1) $display("FAIL busy_after_start got %b want 1", o_busy);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (o_wr_en !== 1'b1) $display("FAIL reset_pre_write got wr_en=%b want 1", o_wr_en);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_wr_en, o_busy, o_done, o_aborted, o_rng_start} !== 5'b0 || o_wr_addr !== '0 ||
        o_wr_data !== '0 || o_rng_seed !== '0)
      $display("FAIL reset_midfill got en=%b busy=%b done=%b ab=%b seed=%h want all 0",
               o_wr_en, o_busy, o_done, o_aborted, o_rng_seed);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (done_cnt != 0 || o_busy !== 1'b0) $display("FAIL reset_no_done got done=%0d busy=%b want 0 0", done_cnt, o_busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_fill("basic_2x3", 2, 3, 32'd123456789, 16'h0100, 0);
  endtask

  task automatic test_stall();
    run_fill("stall_2x3", 2, 3, 32'd123456789, 16'h0100, 1);
  endtask

  task automatic test_empty();
    run_fill("empty_0x5", 0, 5, 32'h1234_5678, 16'h0000, 0);
  endtask

  task automatic test_wrap();
    run_fill("wrap_1x4", 1, 4, 32'h0BAD_BEEF, 16'hFFFE, 0);
  endtask

  task automatic test_abort();
    clear_mon();
    do_start(4, 4, 32'h0042_4242, 16'h0300);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_chk++;
    if (o_wr_en !== 1'b0 || o_busy !== 1'b0) $display("FAIL abort_stop got wr_en=%b busy=%b want 0 0", o_wr_en, o_busy);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (qa.size() != 3 || ab_cnt != 1 || done_cnt != 0)
      $display("FAIL abort_counts got xfers=%0d aborted=%0d done=%0d want 3 1 0", qa.size(), ab_cnt, done_cnt);
    else n_pass++;
    for (int j = 0; j < 3 && j < qd.size(); j++) begin
      n_chk++;
      if (qd[j] !== ref_elem(32'h0042_4242, j, maxv) || qa[j] !== AW'(16'h0300 + j))
        $display("FAIL abort_elem%0d got addr=%h data=%h want addr=%h data=%h", j, qa[j], qd[j],
                 AW'(16'h0300 + j), ref_elem(32'h0042_4242, j, maxv));
      else n_pass++;
    end
    run_fill("after_abort_1x1", 1, 1, 32'h7777_1111, 16'h0500, 0);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    do_start(2, 3, 32'h5555_AAAA, 16'h0200);
    repeat (3) @(posedge clk);
    #1;
    rows = 8'd7; cols = 8'd7; seed = 32'h0101_0101; base = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end("busy_start");
    check_fill("busy_start", 2, 3, 32'h5555_AAAA, 16'h0200);
    run_fill("back_to_back", 3, 2, 32'h1357_9BDF, 16'h0210, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int r, c;
      r = $urandom_range(0, 5);
      c = $urandom_range(0, 5);
      maxv = EW'($urandom);
      run_fill($sformatf("rand%0d", it), r, c, $urandom | 32'h1, AW'($urandom), 2);
    end
    maxv = 16'h00FF;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
